// File: rtl/pc_gen_if.sv
// ============================================================================
// pc_gen_if : fetch-side control and request bundle for pc_gen
// Rev 1.0
// ============================================================================
`default_nettype none

interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            halt_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_target_i;
  logic            fetch_ready_i;
  logic [XLEN-1:0] pc_o;
  logic            ce_o;
  logic            fetch_valid_o;
  logic            misalign_o;

  // master: the PC generator itself; slave: pipeline control + fetch memory
  modport master (
    input  stall_i, halt_i, redirect_i, redirect_target_i, fetch_ready_i,
    output pc_o, ce_o, fetch_valid_o, misalign_o
  );

  modport slave (
    output stall_i, halt_i, redirect_i, redirect_target_i, fetch_ready_i,
    input  pc_o, ce_o, fetch_valid_o, misalign_o
  );
endinterface

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// pc_gen : parametrised IF-stage program counter with boot, halt and redirect
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INST_BYTES   = 4,
  parameter int              BOOT_DELAY   = 1
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.master bus
);

  localparam logic [XLEN-1:0] c_LOW_MASK  = XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] c_STEP      = XLEN'(INST_BYTES);
  localparam logic [3:0]      c_BOOT_LAST = 4'(BOOT_DELAY);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_boot_cnt;
  logic [XLEN-1:0] r_pc;
  logic            r_ce;
  logic            r_misalign;

  logic            w_fire;
  logic [XLEN-1:0] w_target_aligned;
  logic            w_target_misaligned;

  assign w_fire              = r_ce & ~bus.stall_i & bus.fetch_ready_i;
  assign w_target_aligned    = bus.redirect_target_i & ~c_LOW_MASK;
  assign w_target_misaligned = |(bus.redirect_target_i & c_LOW_MASK);

  // The first edge after release is spent leaving reset, so the counter runs
  // 0..BOOT_DELAY and ce_o rises on edge BOOT_DELAY+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_boot_cnt <= '0;
      r_pc       <= RESET_VECTOR;
      r_ce       <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          r_boot_cnt <= r_boot_cnt + 4'd1;
          if (r_boot_cnt == c_BOOT_LAST) begin
            r_state <= ST_RUN;
            r_ce    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.redirect_i) begin
            r_pc       <= w_target_aligned;
            r_misalign <= w_target_misaligned;
          end else if (bus.halt_i) begin
            r_state <= ST_HALT;
            r_ce    <= 1'b0;
          end else if (w_fire) begin
            r_pc <= r_pc + c_STEP;
          end
        end
        ST_HALT: begin
          if (bus.redirect_i) begin
            r_pc       <= w_target_aligned;
            r_misalign <= w_target_misaligned;
            r_state    <= ST_RUN;
            r_ce       <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_BOOT;
          r_ce    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_o          = r_pc;
  assign bus.ce_o          = r_ce;
  assign bus.misalign_o    = r_misalign;
  assign bus.fetch_valid_o = r_ce & ~bus.stall_i;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// tb_pc_gen : self-checking bench for pc_gen (32-bit and 64-bit instances)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_gen;

  localparam int          BD  = 3;
  localparam int          IB  = 4;
  localparam logic [31:0] RV  = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) bus ();
  pc_gen_if #(.XLEN(64)) bus64 ();

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .INST_BYTES(IB), .BOOT_DELAY(BD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  pc_gen #(.XLEN(64), .RESET_VECTOR(64'h10), .INST_BYTES(2), .BOOT_DELAY(1)) dut64 (
    .clk(clk), .rst(rst2), .bus(bus64)
  );

  // Reference model: edges left before fetching may start, a halted flag,
  // the expected PC and the expected misalignment pulse.
  int          m_boot_left;
  bit          m_halted;
  logic [31:0] m_pc;
  bit          m_mis;
  bit          m_stall;

  function automatic logic exp_ce();
    return (m_boot_left == 0) && !m_halted;
  endfunction

  task automatic model_reset();
    m_boot_left = BD + 1;
    m_halted    = 1'b0;
    m_pc        = RV;
    m_mis       = 1'b0;
  endtask

  task automatic drive(input bit st, input bit ha, input bit rd,
                       input logic [31:0] tg, input bit rdy);
    bus.stall_i           = st;
    bus.halt_i            = ha;
    bus.redirect_i        = rd;
    bus.redirect_target_i = tg;
    bus.fetch_ready_i     = rdy;
    m_stall               = st;
    m_mis                 = 1'b0;
    if (m_boot_left > 0) begin
      m_boot_left = m_boot_left - 1;
    end else if (m_halted) begin
      if (rd) begin
        m_pc     = tg - (tg % IB);
        m_mis    = (tg % IB) != 0;
        m_halted = 1'b0;
      end
    end else if (rd) begin
      m_pc  = tg - (tg % IB);
      m_mis = (tg % IB) != 0;
    end else if (ha) begin
      m_halted = 1'b1;
    end else if (!st && rdy) begin
      m_pc = 32'((64'(m_pc) + IB) % 64'h1_0000_0000);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive64(input bit rd, input logic [63:0] tg, input bit rdy);
    bus64.stall_i           = 1'b0;
    bus64.halt_i            = 1'b0;
    bus64.redirect_i        = rd;
    bus64.redirect_target_i = tg;
    bus64.fetch_ready_i     = rdy;
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; asserts rst mid-cycle with no edge in between.
  task automatic assert_rst();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 0, 1, 32'h0000_3000, 0);
    assert_rst();
    n_checks++;
    if (bus.pc_o !== RV || bus.ce_o !== 1'b0 || bus.fetch_valid_o !== 1'b0 || bus.misalign_o !== 1'b0)
      $display("FAIL async_reset: pc=%h ce=%b valid=%b mis=%b, need pc=%h ce=0 valid=0 mis=0",
               bus.pc_o, bus.ce_o, bus.fetch_valid_o, bus.misalign_o, RV);
    else n_pass++;
    release_rst();
    for (int e = 1; e <= BD + 1; e++) begin
      drive(0, 1, 1, 32'h0000_5004, 1);
      n_checks++;
      if (bus.fetch_valid_o !== (e == BD + 1) || bus.pc_o !== RV)
        $display("FAIL boot_edge%0d: valid=%b pc=%h, need valid=%b pc=%h",
                 e, bus.fetch_valid_o, bus.pc_o, (e == BD + 1), RV);
      else n_pass++;
    end
  endtask

  task automatic test_handshake();
    logic [31:0] exp_seq [4] = '{32'h104, 32'h104, 32'h104, 32'h108};
    bit          rdy_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    n_checks++;
    if (bus.pc_o !== 32'h100 || bus.fetch_valid_o !== 1'b1)
      $display("FAIL hs_start: pc=%h valid=%b, need pc=00000100 valid=1", bus.pc_o, bus.fetch_valid_o);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 32'h0, rdy_seq[i]);
      n_checks++;
      if (bus.pc_o !== exp_seq[i] || bus.fetch_valid_o !== 1'b1 || m_pc !== exp_seq[i])
        $display("FAIL hs_step%0d: pc=%h valid=%b, need pc=%h valid=1",
                 i, bus.pc_o, bus.fetch_valid_o, exp_seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 32'h0, 1);
      n_checks++;
      if (bus.pc_o !== 32'h108 || bus.fetch_valid_o !== 1'b0 || bus.ce_o !== 1'b1)
        $display("FAIL stall%0d: pc=%h valid=%b ce=%b, need pc=00000108 valid=0 ce=1",
                 i, bus.pc_o, bus.fetch_valid_o, bus.ce_o);
      else n_pass++;
    end
    drive(0, 0, 0, 32'h0, 1);
    n_checks++;
    if (bus.pc_o !== 32'h10C || bus.fetch_valid_o !== 1'b1)
      $display("FAIL stall_resume: pc=%h valid=%b, need pc=0000010c valid=1", bus.pc_o, bus.fetch_valid_o);
    else n_pass++;
  endtask

  task automatic test_redirect();
    drive(0, 0, 1, 32'h0000_2002, 1);
    n_checks++;
    if (bus.pc_o !== 32'h2000 || bus.misalign_o !== 1'b1)
      $display("FAIL redirect: pc=%h mis=%b, need pc=00002000 mis=1", bus.pc_o, bus.misalign_o);
    else n_pass++;
    drive(0, 0, 0, 32'h0, 0);
    n_checks++;
    if (bus.pc_o !== 32'h2000 || bus.misalign_o !== 1'b0)
      $display("FAIL redirect_after: pc=%h mis=%b, need pc=00002000 mis=0", bus.pc_o, bus.misalign_o);
    else n_pass++;
  endtask

  task automatic test_halt_wrap();
    drive(0, 0, 1, 32'hFFFF_FFFC, 0);
    drive(0, 0, 0, 32'h0, 1);
    n_checks++;
    if (bus.pc_o !== 32'h0 || bus.misalign_o !== 1'b0)
      $display("FAIL wrap: pc=%h mis=%b, need pc=00000000 mis=0", bus.pc_o, bus.misalign_o);
    else n_pass++;
    drive(0, 1, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.ce_o !== 1'b0 || bus.fetch_valid_o !== 1'b0 || bus.pc_o !== 32'h0)
        $display("FAIL halted%0d: ce=%b valid=%b pc=%h, need ce=0 valid=0 pc=00000000",
                 i, bus.ce_o, bus.fetch_valid_o, bus.pc_o);
      else n_pass++;
      drive(i[0], 1, 0, 32'h0, 1);
    end
    drive(0, 0, 1, 32'h0000_0040, 0);
    n_checks++;
    if (bus.ce_o !== 1'b1 || bus.fetch_valid_o !== 1'b1 || bus.pc_o !== 32'h40)
      $display("FAIL halt_exit: ce=%b valid=%b pc=%h, need ce=1 valid=1 pc=00000040",
               bus.ce_o, bus.fetch_valid_o, bus.pc_o);
    else n_pass++;
  endtask

  task automatic test_conflicts();
    drive(0, 1, 1, 32'h0000_0080, 1);
    n_checks++;
    if (bus.ce_o !== 1'b1 || bus.pc_o !== 32'h80)
      $display("FAIL redirect_halt: ce=%b pc=%h, need ce=1 pc=00000080", bus.ce_o, bus.pc_o);
    else n_pass++;
    drive(0, 1, 0, 32'h0, 1);
    n_checks++;
    if (bus.ce_o !== 1'b0)
      $display("FAIL halt_reissue: ce=%b, need ce=0", bus.ce_o);
    else n_pass++;
    assert_rst();
    n_checks++;
    if (bus.pc_o !== RV || bus.ce_o !== 1'b0)
      $display("FAIL reset_in_halt: pc=%h ce=%b, need pc=%h ce=0", bus.pc_o, bus.ce_o, RV);
    else n_pass++;
    release_rst();
    for (int e = 0; e <= BD; e++) drive(0, 0, 0, 32'h0, 0);
    n_checks++;
    if (bus.ce_o !== 1'b1 || bus.pc_o !== RV)
      $display("FAIL reboot: ce=%b pc=%h, need ce=1 pc=%h", bus.ce_o, bus.pc_o, RV);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tg;
      tg = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0, tg, $urandom_range(0, 1) == 1);
      n_checks++;
      if (bus.pc_o !== m_pc || bus.ce_o !== exp_ce() || bus.misalign_o !== m_mis ||
          bus.fetch_valid_o !== (exp_ce() && !m_stall))
        $display("FAIL random%0d: pc=%h ce=%b mis=%b valid=%b, need pc=%h ce=%b mis=%b valid=%b",
                 i, bus.pc_o, bus.ce_o, bus.misalign_o, bus.fetch_valid_o,
                 m_pc, exp_ce(), m_mis, exp_ce() && !m_stall);
      else n_pass++;
    end
  endtask

  task automatic test_param64();
    logic [63:0] exp_seq [4] = '{64'h12, 64'h12, 64'h12, 64'h14};
    bit          rdy_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    rst2 = 1'b0;
    drive64(0, 64'h0, 1);
    n_checks++;
    if (bus64.fetch_valid_o !== 1'b0 || bus64.pc_o !== 64'h10)
      $display("FAIL p64_boot1: valid=%b pc=%h, need valid=0 pc=10", bus64.fetch_valid_o, bus64.pc_o);
    else n_pass++;
    drive64(0, 64'h0, 1);
    n_checks++;
    if (bus64.fetch_valid_o !== 1'b1 || bus64.pc_o !== 64'h10)
      $display("FAIL p64_boot2: valid=%b pc=%h, need valid=1 pc=10", bus64.fetch_valid_o, bus64.pc_o);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive64(0, 64'h0, rdy_seq[i]);
      n_checks++;
      if (bus64.pc_o !== exp_seq[i] || bus64.fetch_valid_o !== 1'b1)
        $display("FAIL p64_step%0d: pc=%h valid=%b, need pc=%h valid=1",
                 i, bus64.pc_o, bus64.fetch_valid_o, exp_seq[i]);
      else n_pass++;
    end
    drive64(1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    n_checks++;
    if (bus64.pc_o !== 64'hFFFF_FFFF_FFFF_FFFE || bus64.misalign_o !== 1'b1)
      $display("FAIL p64_redirect: pc=%h mis=%b, need pc=fffffffffffffffe mis=1",
               bus64.pc_o, bus64.misalign_o);
    else n_pass++;
    drive64(0, 64'h0, 1);
    n_checks++;
    if (bus64.pc_o !== 64'h0 || bus64.misalign_o !== 1'b0)
      $display("FAIL p64_wrap: pc=%h mis=%b, need pc=0 mis=0", bus64.pc_o, bus64.misalign_o);
    else n_pass++;
  endtask

  initial begin
    rst  = 1'b1;
    rst2 = 1'b1;
    bus.stall_i = 1'b0; bus.halt_i = 1'b0; bus.redirect_i = 1'b0;
    bus.redirect_target_i = '0; bus.fetch_ready_i = 1'b0;
    bus64.stall_i = 1'b0; bus64.halt_i = 1'b0; bus64.redirect_i = 1'b0;
    bus64.redirect_target_i = '0; bus64.fetch_ready_i = 1'b0;
    model_reset();
    m_stall = 1'b0;
    repeat (2) @(posedge clk);
    release_rst();
    for (int e = 0; e <= BD + 2; e++) drive(0, 0, 0, 32'h0, 0);
    test_reset();
    test_handshake();
    test_stall();
    test_redirect();
    test_halt_wrap();
    test_conflicts();
    test_random();
    test_param64();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
